// File: rtl/cnn_layer_accel_job_pkg.sv
// Shared job-interface definitions for the layer accelerator job controller
// and the verification driver that builds job descriptors.
package cnn_layer_accel_job_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetchReq,
    StFetch,
    StExec,
    StComplete
  } job_state_t;

  localparam int unsigned JobParamsWidth  = 128;
  localparam int unsigned DimFieldWidth   = 16;
  localparam int unsigned SmallFieldWidth = 4;

  // Bit offsets of each field inside the 128-bit descriptor
  localparam int unsigned RowsOffset       = 0;
  localparam int unsigned ColsOffset       = 16;
  localparam int unsigned DepthOffset      = 32;
  localparam int unsigned KernelsOffset    = 48;
  localparam int unsigned KernelSizeOffset = 64;
  localparam int unsigned StrideOffset     = 68;
  localparam int unsigned PaddingOffset    = 72;
  localparam int unsigned ReservedOffset   = 76;

  // Descriptor layout, MSB first
  typedef struct packed {
    logic [51:0] reserved;
    logic [3:0]  padding;
    logic [3:0]  stride;
    logic [3:0]  kernel_size;
    logic [15:0] num_kernels;
    logic [15:0] depth;
    logic [15:0] num_cols;
    logic [15:0] num_rows;
  } job_params_t;

endpackage

// File: rtl/cnn_layer_accel_beat_counter.sv
// Loadable up-counter with terminal-count detect; shared by the pixel and
// weight fetch paths.
module cnn_layer_accel_beat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_value_i,
  input  logic             inc_i,
  input  logic [Width-1:0] terminal_i,
  output logic [Width-1:0] count_o,
  output logic             last_o
);

  logic [Width-1:0] count_q, count_d;

  // Next count: clear wins over load, load wins over increment
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_value_i;
    end else if (inc_i) begin
      count_d = count_q + Width'(1);
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  // Flags the increment that lands exactly on the terminal value
  assign last_o  = inc_i && ((count_q + Width'(1)) == terminal_i);

endmodule

// File: rtl/cnn_layer_accel_job_ctrl.sv
// Responder side of the quad job handshake: latches the job descriptor,
// requests the pixel fetch, meters pixel beats, waits for the core and
// holds completion until the host acknowledges.
module cnn_layer_accel_job_ctrl
  import cnn_layer_accel_job_pkg::*;
#(
  parameter int unsigned C_DIM_WIDTH      = 16,
  parameter int unsigned C_BEAT_CNT_WIDTH = 32
) (
  input  logic                   clk_if,
  input  logic                   rst,
  input  logic                   job_start,
  output logic                   job_accept,
  input  logic [127:0]           job_parameters,
  output logic                   job_fetch_request,
  input  logic                   job_fetch_ack,
  output logic                   job_fetch_complete,
  output logic                   job_complete,
  input  logic                   job_complete_ack,
  input  logic                   pixel_valid,
  output logic                   pixel_ready,
  output logic                   pixel_fire,
  input  logic                   core_done,
  output logic [C_DIM_WIDTH-1:0] cfg_num_rows,
  output logic [C_DIM_WIDTH-1:0] cfg_num_cols,
  output logic [C_DIM_WIDTH-1:0] cfg_depth,
  output logic [C_DIM_WIDTH-1:0] cfg_num_kernels,
  output logic [3:0]             cfg_kernel_size,
  output logic [3:0]             cfg_stride,
  output logic [3:0]             cfg_padding,
  output logic                   job_err,
  output logic                   busy
);

  job_state_t state_q, state_d;

  logic [C_DIM_WIDTH-1:0]      in_rows, in_cols, min_dim;
  logic [3:0]                  in_ksize;
  logic                        params_bad;
  logic                        latch_cfg;
  logic                        accept_d, fetch_done_d, err_d;
  logic                        cnt_clear, cnt_load, cnt_last;
  logic [C_BEAT_CNT_WIDTH-1:0] beat_cnt, beats_total_q;

  logic                        accept_q, fetch_req_q, fetch_done_q, complete_q;
  logic                        ready_q, err_q, busy_q;
  logic [C_DIM_WIDTH-1:0]      rows_q, cols_q, depth_q, kernels_q;
  logic [3:0]                  ksize_q, stride_q, pad_q;
  logic                        unused_params;

  assign in_rows  = job_parameters[RowsOffset +: C_DIM_WIDTH];
  assign in_cols  = job_parameters[ColsOffset +: C_DIM_WIDTH];
  assign in_ksize = job_parameters[KernelSizeOffset +: SmallFieldWidth];
  assign min_dim  = (in_rows < in_cols) ? in_rows : in_cols;

  // A kernel that does not fit the frame is rejected straight to completion
  assign params_bad = (in_rows == '0) || (in_cols == '0) || (in_ksize == '0) ||
                      (C_DIM_WIDTH'(in_ksize) > min_dim);

  assign unused_params = ^job_parameters[JobParamsWidth-1:ReservedOffset];

  cnn_layer_accel_beat_counter #(
    .Width(C_BEAT_CNT_WIDTH)
  ) u_beat_counter (
    .clk_i       (clk_if),
    .rst_ni      (rst),
    .clear_i     (cnt_clear),
    .load_i      (cnt_load),
    .load_value_i('0),
    .inc_i       (pixel_fire),
    .terminal_i  (beats_total_q),
    .count_o     (beat_cnt),
    .last_o      (cnt_last)
  );

  // Next-state and pulse decode
  always_comb begin
    state_d      = state_q;
    accept_d     = 1'b0;
    fetch_done_d = 1'b0;
    err_d        = err_q;
    latch_cfg    = 1'b0;
    cnt_clear    = 1'b0;
    cnt_load     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (job_start) begin
          latch_cfg = 1'b1;
          accept_d  = 1'b1;
          cnt_load  = 1'b1;
          if (params_bad) begin
            err_d   = 1'b1;
            state_d = StComplete;
          end else begin
            state_d = StFetchReq;
          end
        end
      end
      StFetchReq: begin
        if (job_fetch_ack) state_d = StFetch;
      end
      StFetch: begin
        if (cnt_last || (beat_cnt >= beats_total_q)) begin
          fetch_done_d = 1'b1;
          state_d      = StExec;
        end
      end
      StExec: begin
        if (core_done) state_d = StComplete;
      end
      StComplete: begin
        if (job_complete_ack) begin
          err_d     = 1'b0;
          cnt_clear = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, registered outputs and latched configuration
  always_ff @(posedge clk_if) begin
    if (!rst) begin
      state_q       <= StIdle;
      accept_q      <= 1'b0;
      fetch_req_q   <= 1'b0;
      fetch_done_q  <= 1'b0;
      complete_q    <= 1'b0;
      ready_q       <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      rows_q        <= '0;
      cols_q        <= '0;
      depth_q       <= '0;
      kernels_q     <= '0;
      ksize_q       <= '0;
      stride_q      <= '0;
      pad_q         <= '0;
      beats_total_q <= '0;
    end else begin
      state_q      <= state_d;
      accept_q     <= accept_d;
      fetch_done_q <= fetch_done_d;
      err_q        <= err_d;
      // Level outputs follow the state being entered so they align with it
      fetch_req_q  <= (state_d == StFetchReq);
      complete_q   <= (state_d == StComplete);
      ready_q      <= (state_d == StFetch);
      busy_q       <= (state_d != StIdle);
      if (latch_cfg) begin
        rows_q        <= in_rows;
        cols_q        <= in_cols;
        depth_q       <= job_parameters[DepthOffset +: C_DIM_WIDTH];
        kernels_q     <= job_parameters[KernelsOffset +: C_DIM_WIDTH];
        ksize_q       <= in_ksize;
        stride_q      <= job_parameters[StrideOffset +: SmallFieldWidth];
        pad_q         <= job_parameters[PaddingOffset +: SmallFieldWidth];
        beats_total_q <= C_BEAT_CNT_WIDTH'(in_rows) * C_BEAT_CNT_WIDTH'(in_cols);
      end
    end
  end

  assign pixel_fire         = pixel_valid & ready_q;
  assign job_accept         = accept_q;
  assign job_fetch_request  = fetch_req_q;
  assign job_fetch_complete = fetch_done_q;
  assign job_complete       = complete_q;
  assign pixel_ready        = ready_q;
  assign job_err            = err_q;
  assign busy               = busy_q;
  assign cfg_num_rows       = rows_q;
  assign cfg_num_cols       = cols_q;
  assign cfg_depth          = depth_q;
  assign cfg_num_kernels    = kernels_q;
  assign cfg_kernel_size    = ksize_q;
  assign cfg_stride         = stride_q;
  assign cfg_padding        = pad_q;

endmodule

// File: tb/tb_cnn_layer_accel_job_ctrl.sv
// Scoreboard bench for the job controller: the driver pushes expected
// accept / fetch-complete / completion records, the monitor pops them when
// the DUT presents the matching output.
module tb_cnn_layer_accel_job_ctrl;
  import cnn_layer_accel_job_pkg::*;

  logic         clk_if = 1'b0;
  logic         rst = 1'b0;
  logic         job_start = 1'b0;
  logic         job_accept;
  logic [127:0] job_parameters = '0;
  logic         job_fetch_request;
  logic         job_fetch_ack = 1'b0;
  logic         job_fetch_complete;
  logic         job_complete;
  logic         job_complete_ack = 1'b0;
  logic         pixel_valid = 1'b0;
  logic         pixel_ready;
  logic         pixel_fire;
  logic         core_done = 1'b0;
  logic [15:0]  cfg_num_rows, cfg_num_cols, cfg_depth, cfg_num_kernels;
  logic [3:0]   cfg_kernel_size, cfg_stride, cfg_padding;
  logic         job_err;
  logic         busy;

  always #5 clk_if = ~clk_if;

  cnn_layer_accel_job_ctrl dut (
    .clk_if            (clk_if),
    .rst               (rst),
    .job_start         (job_start),
    .job_accept        (job_accept),
    .job_parameters    (job_parameters),
    .job_fetch_request (job_fetch_request),
    .job_fetch_ack     (job_fetch_ack),
    .job_fetch_complete(job_fetch_complete),
    .job_complete      (job_complete),
    .job_complete_ack  (job_complete_ack),
    .pixel_valid       (pixel_valid),
    .pixel_ready       (pixel_ready),
    .pixel_fire        (pixel_fire),
    .core_done         (core_done),
    .cfg_num_rows      (cfg_num_rows),
    .cfg_num_cols      (cfg_num_cols),
    .cfg_depth         (cfg_depth),
    .cfg_num_kernels   (cfg_num_kernels),
    .cfg_kernel_size   (cfg_kernel_size),
    .cfg_stride        (cfg_stride),
    .cfg_padding       (cfg_padding),
    .job_err           (job_err),
    .busy              (busy)
  );

  typedef struct {
    job_params_t p;
  } acc_exp_t;

  typedef struct {
    logic err;
    int   beats;
  } cmp_exp_t;

  int       n_checks = 0;
  int       n_fail = 0;
  acc_exp_t q_acc[$];
  int       q_fetch[$];
  cmp_exp_t q_cmp[$];
  int       fires = 0;
  logic     cmp_prev = 1'b0;
  logic     cur_err = 1'b0;
  acc_exp_t ea;
  cmp_exp_t ec;
  int       ef;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_if);
    #1;
  endtask

  function automatic job_params_t mk(input int r, input int c, input int d, input int k,
                                     input int ks, input int st, input int pd);
    job_params_t p;
    p.reserved    = {20'h0, $urandom()};
    p.padding     = pd[3:0];
    p.stride      = st[3:0];
    p.kernel_size = ks[3:0];
    p.num_kernels = k[15:0];
    p.depth       = d[15:0];
    p.num_cols    = c[15:0];
    p.num_rows    = r[15:0];
    return p;
  endfunction

  // Reference rules: a job is rejected when the frame is empty or the kernel
  // is zero or larger than the smaller frame dimension.
  function automatic logic model_err(input job_params_t p);
    int r = int'(p.num_rows);
    int c = int'(p.num_cols);
    int k = int'(p.kernel_size);
    int m = (r < c) ? r : c;
    return (r == 0) || (c == 0) || (k == 0) || (k > m);
  endfunction

  task automatic push_expect(input job_params_t p);
    acc_exp_t a;
    cmp_exp_t e;
    int       beats;
    a.p     = p;
    cur_err = model_err(p);
    beats   = cur_err ? 0 : int'(p.num_rows) * int'(p.num_cols);
    q_acc.push_back(a);
    if (!cur_err) q_fetch.push_back(beats);
    e.err   = cur_err;
    e.beats = beats;
    q_cmp.push_back(e);
  endtask

  task automatic issue_job(input job_params_t p);
    push_expect(p);
    job_parameters = p;
    job_start      = 1'b1;
    tick();
    job_start = 1'b0;
    chk("job_accept pulse", job_accept, 1);
  endtask

  task automatic serve_job(input int vmode, input int req_delay, input int core_delay,
                           input int cmp_delay, input bit inject, input bit chain,
                           input job_params_t next_p);
    bit done;
    if (!cur_err) begin
      for (int i = 0; i < req_delay; i++) begin
        chk("fetch_request held", job_fetch_request, 1);
        tick();
      end
      chk("fetch_request before ack", job_fetch_request, 1);
      job_fetch_ack = 1'b1;
      tick();
      job_fetch_ack = 1'b0;
      chk("fetch_request dropped", job_fetch_request, 0);
      done = 1'b0;
      for (int i = 0; i < 20000 && !done; i++) begin
        case (vmode)
          0:       pixel_valid = 1'b1;
          1:       pixel_valid = (i % 2 == 0);
          default: begin
            pixel_valid      = 1'($urandom_range(0, 1));
            job_complete_ack = 1'($urandom_range(0, 1));
          end
        endcase
        if (inject && i == 37) begin
          job_parameters = mk(7, 7, 1, 1, 3, 1, 0);
          job_start      = 1'b1;
        end else begin
          job_start = 1'b0;
        end
        tick();
        if (job_fetch_complete) done = 1'b1;
      end
      pixel_valid      = 1'b0;
      job_start        = 1'b0;
      job_complete_ack = 1'b0;
      chk("fetch finished within budget", done, 1);
    end else begin
      chk("no fetch request on rejected job", job_fetch_request, 0);
    end
    for (int i = 0; i < core_delay; i++) begin
      job_start = inject && (i == 1);
      tick();
    end
    job_start = 1'b0;
    if (!cur_err) begin
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
    end
    for (int i = 0; i < 10 && !job_complete; i++) tick();
    chk("job_complete raised", job_complete, 1);
    chk("job_err for job", job_err, cur_err);
    if (inject) chk("cfg_num_rows kept while busy", cfg_num_rows, 20);
    for (int i = 0; i < cmp_delay; i++) begin
      chk("job_complete held", job_complete, 1);
      tick();
    end
    job_complete_ack = 1'b1;
    if (chain) begin
      job_parameters = next_p;
      job_start      = 1'b1;
    end
    tick();
    job_complete_ack = 1'b0;
    chk("job_complete cleared", job_complete, 0);
    chk("job_err cleared", job_err, 0);
    chk("busy cleared", busy, 0);
    if (chain) begin
      chk("no accept on ack cycle", job_accept, 0);
      push_expect(next_p);
      tick();
      chk("chained job_accept", job_accept, 1);
      job_start = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " job_accept"}, job_accept, 0);
    chk({tag, " job_fetch_request"}, job_fetch_request, 0);
    chk({tag, " job_fetch_complete"}, job_fetch_complete, 0);
    chk({tag, " job_complete"}, job_complete, 0);
    chk({tag, " pixel_ready"}, pixel_ready, 0);
    chk({tag, " pixel_fire"}, pixel_fire, 0);
    chk({tag, " job_err"}, job_err, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " cfg dims"}, {cfg_num_rows, cfg_num_cols, cfg_depth, cfg_num_kernels}, 0);
    chk({tag, " cfg small"}, {cfg_kernel_size, cfg_stride, cfg_padding}, 0);
  endtask

  // Monitor: pops expectations as the DUT presents each event
  initial begin
    forever begin
      @(negedge clk_if);
      if (!rst) begin
        fires    = 0;
        cmp_prev = 1'b0;
      end else begin
        if (job_accept) begin
          if (q_acc.size() == 0) begin
            chk("unexpected job_accept", 1, 0);
          end else begin
            ea = q_acc.pop_front();
            chk("cfg_num_rows", cfg_num_rows, ea.p.num_rows);
            chk("cfg_num_cols", cfg_num_cols, ea.p.num_cols);
            chk("cfg_depth", cfg_depth, ea.p.depth);
            chk("cfg_num_kernels", cfg_num_kernels, ea.p.num_kernels);
            chk("cfg_small_fields", {cfg_kernel_size, cfg_stride, cfg_padding},
                {ea.p.kernel_size, ea.p.stride, ea.p.padding});
          end
          fires = 0;
        end
        if (pixel_fire) fires++;
        if (job_fetch_complete) begin
          if (q_fetch.size() == 0) begin
            chk("unexpected job_fetch_complete", 1, 0);
          end else begin
            ef = q_fetch.pop_front();
            chk("beats at fetch_complete", fires, ef);
            chk("pixel_ready low after last beat", pixel_ready, 0);
          end
        end
        if (job_complete && !cmp_prev) begin
          if (q_cmp.size() == 0) begin
            chk("unexpected job_complete", 1, 0);
          end else begin
            ec = q_cmp.pop_front();
            chk("job_err at completion", job_err, ec.err);
            chk("total beats at completion", fires, ec.beats);
          end
        end
        cmp_prev = job_complete;
      end
    end
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    job_params_t p20, pnext;
    p20 = mk(20, 20, 8, 5, 3, 1, 0);
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b1;
    tick();

    // 20x20, valid held high, stray job_start in FETCH and EXEC
    issue_job(p20);
    serve_job(0, 0, 3, 2, 1'b1, 1'b0, p20);

    // 25x25, 50% valid duty, 7-cycle fetch ack delay
    issue_job(mk(25, 25, 4, 2, 3, 2, 1));
    serve_job(1, 7, 2, 1, 1'b0, 1'b0, p20);

    // Rejected descriptors
    issue_job(mk(0, 10, 1, 1, 3, 1, 0));
    serve_job(0, 0, 2, 1, 1'b0, 1'b0, p20);
    issue_job(mk(4, 4, 1, 1, 5, 1, 0));
    serve_job(0, 0, 2, 3, 1'b0, 1'b0, p20);

    // Reset after 100 of 400 beats, then a clean 20x20 job
    issue_job(p20);
    job_fetch_ack = 1'b1;
    tick();
    job_fetch_ack = 1'b0;
    pixel_valid   = 1'b1;
    for (int i = 0; i < 1000 && fires < 100; i++) tick();
    chk("reached 100 beats before reset", fires >= 100, 1);
    rst         = 1'b0;
    pixel_valid = 1'b0;
    tick();
    check_idle("mid-op reset");
    q_fetch.delete();
    q_cmp.delete();
    rst = 1'b1;
    tick();
    issue_job(p20);
    serve_job(0, 1, 1, 1, 1'b0, 1'b0, p20);

    // Back-to-back: start held through the completion ack
    pnext = mk(5, 6, 2, 3, 3, 1, 1);
    issue_job(mk(3, 4, 1, 1, 2, 1, 0));
    serve_job(2, 1, 1, 1, 1'b0, 1'b1, pnext);
    serve_job(2, 0, 2, 0, 1'b0, 1'b0, p20);

    // Random descriptors, random valid and handshake timing
    for (int j = 0; j < 8; j++) begin
      issue_job(mk($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 500),
                   $urandom_range(0, 500), $urandom_range(0, 6), $urandom_range(0, 15),
                   $urandom_range(0, 15)));
      serve_job(2, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                1'b0, 1'b0, p20);
    end

    repeat (3) tick();
    chk("accept queue drained", q_acc.size(), 0);
    chk("fetch queue drained", q_fetch.size(), 0);
    chk("completion queue drained", q_cmp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
